// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key-schedule blocks.
package aes_pkg;

  localparam int NR   = 10;
  localparam int RK_W = 128;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic {IDLE, RUN} state_e;

  // Round constant bytes, RCON[r] for r = 1..10.
  localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) rc = RCON[r];
    return rc;
  endfunction

endpackage

// File: rtl/S_Sbox.sv
// AES forward byte S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module S_Sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 is the inverse for x != 0 and maps 0 to 0, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign out_byte = affine(gf_inv(in_byte));

endmodule

// File: rtl/aes_subword32.sv
// 32-bit SubWord: the byte S-box applied to each byte of a word.
module aes_subword32 (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    S_Sbox u_sbox (
      .in_byte (word_in[8*g +: 8]),
      .out_byte(word_out[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: loads the round-10 key and emits round keys 10..0
// on a valid/ready stream, recomputing each previous key from the current one.
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [RK_W-1:0] last_key,
  output logic            busy,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [RK_W-1:0] rk_out,
  output logic [3:0]      rk_index,
  output logic            done
);

  state_e          state_q, state_d;
  logic [RK_W-1:0] key_q, key_d;
  logic [3:0]      idx_q, idx_d;
  logic            done_q, done_d;

  logic [31:0]     k0, k1, k2, k3;
  logic [31:0]     p0, p1, p2, p3;
  logic [31:0]     rot_p3, sub_p3;
  logic [RK_W-1:0] prev_key;

  assign {k0, k1, k2, k3} = key_q;

  // Undo one forward-expansion step; p3 is the old w[i-1] feeding the g() function.
  assign p3     = k3 ^ k2;
  assign p2     = k2 ^ k1;
  assign p1     = k1 ^ k0;
  assign rot_p3 = {p3[23:0], p3[31:24]};

  aes_subword32 u_subword (
    .word_in (rot_p3),
    .word_out(sub_p3)
  );

  assign p0       = k0 ^ sub_p3 ^ {rcon_of(idx_q), 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          idx_d   = LAST_ROUND;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (idx_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = prev_key;
            idx_d = idx_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign rk_valid = (state_q == RUN);
  assign rk_out   = key_q;
  assign rk_index = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed and random checks of the inverse key schedule against FIPS-197 and a forward-expansion model.
module tb_aes_inv_key_sched;

  localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready;
  logic         busy, rk_valid, done;
  logic [127:0] last_key, rk_out;
  logic [3:0]   rk_index;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   tb_sbox [0:255];
  logic [7:0]   tb_rc   [1:10];
  logic [127:0] ref_rk  [0:10];
  logic [127:0] got_key [0:15];
  logic [3:0]   got_idx [0:15];
  int           n_beats, n_dones, g_last_beat;

  aes_inv_key_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .last_key(last_key),
    .busy    (busy),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .rk_out  (rk_out),
    .rk_index(rk_index),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // Inverse by exhaustive search, affine map in its bitwise form.
  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      tb_sbox[x] = s;
    end
    tb_rc[1] = 8'h01; tb_rc[2] = 8'h02; tb_rc[3] = 8'h04; tb_rc[4] = 8'h08; tb_rc[5]  = 8'h10;
    tb_rc[6] = 8'h20; tb_rc[7] = 8'h40; tb_rc[8] = 8'h80; tb_rc[9] = 8'h1b; tb_rc[10] = 8'h36;
  endtask

  task automatic fwd_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    {w[0], w[1], w[2], w[3]} = key;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
        t = t ^ {tb_rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called #1 after a clock edge with the block in IDLE.
  task automatic launch(input logic [127:0] key);
    start    = 1'b1;
    last_key = key;
    @(posedge clk); #1;
    start    = 1'b0;
    last_key = ~key;
    check("first_busy",  busy, 1);
    check("first_valid", rk_valid, 1);
    check("first_index", rk_index, 10);
    check("first_key",   rk_out, key);
  endtask

  task automatic drain(input bit bp, input int restart_idx, input logic [127:0] key2,
                       input bit b2b, input logic [127:0] key3);
    int           done_cyc, last_beat;
    logic         stall;
    logic [127:0] hold_k;
    logic [3:0]   hold_i;
    done_cyc  = -1;
    last_beat = -1;
    n_beats   = 0;
    n_dones   = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (done_cyc >= 0) begin
        check("done_one_cycle", done, 0);
        start    = 1'b0;
        last_key = rand128();
        break;
      end
      if (done) begin
        n_dones++;
        done_cyc = cyc;
        check("done_after_last", cyc, last_beat + 1);
        check("idle_at_done", busy | rk_valid, 0);
      end
      rk_ready = bp ? (cyc % 3 == 0) : 1'b1;
      start    = (restart_idx >= 0) && rk_valid && (rk_index == 4'(restart_idx));
      last_key = start ? key2 : rand128();
      if (b2b && done) begin
        start    = 1'b1;
        last_key = key3;
      end
      if (rk_valid && rk_ready && n_beats < 16) begin
        got_idx[n_beats] = rk_index;
        got_key[n_beats] = rk_out;
        n_beats++;
        if (rk_index == 4'd0) last_beat = cyc;
      end
      stall  = rk_valid && !rk_ready;
      hold_k = rk_out;
      hold_i = rk_index;
      @(posedge clk); #1;
      if (stall) begin
        check("stall_key", rk_out, hold_k);
        check("stall_idx", rk_index, hold_i);
      end
    end
    check("done_count", n_dones, 1);
    g_last_beat = last_beat;
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_beats"}, n_beats, 11);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_idx%0d", tag, 10 - i), got_idx[i], 10 - i);
      check($sformatf("%s_key%0d", tag, 10 - i), got_key[i], ref_rk[10 - i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k2;
    build_sbox();
    rst_n    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    last_key = '0;
    #12;
    check("rst_busy",  busy, 0);
    check("rst_valid", rk_valid, 0);
    check("rst_out",   rk_out, 0);
    check("rst_index", rk_index, 0);
    check("rst_done",  done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 appendix A.1 key, ready held high.
    fwd_expand(FIPS0);
    launch(FIPS10);
    drain(1'b0, -1, '0, 1'b0, '0);
    check_seq("fips");
    check("fips_k10", got_key[0], FIPS10);
    check("fips_k9",  got_key[1], FIPS9);
    check("fips_k0",  got_key[10], FIPS0);
    check("fips_last_cycle", g_last_beat, 10);

    launch(FIPS10);
    drain(1'b1, -1, '0, 1'b0, '0);
    check_seq("bp");

    launch(FIPS10);
    drain(1'b0, 6, rand128(), 1'b0, '0);
    check_seq("restart");

    // Reset in the middle of a run.
    launch(FIPS10);
    rk_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rk_valid && rk_index == 4'd4) break;
      @(posedge clk); #1;
    end
    check("reach_idx4", rk_index, 4);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  busy, 0);
    check("arst_valid", rk_valid, 0);
    check("arst_out",   rk_out, 0);
    check("arst_index", rk_index, 0);
    check("arst_done",  done, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("arst_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    launch(FIPS10);
    drain(1'b0, -1, '0, 1'b0, '0);
    check_seq("post_rst");

    // Start asserted in the same cycle done is high.
    k2 = rand128();
    launch(FIPS10);
    drain(1'b0, -1, '0, 1'b1, k2);
    check_seq("b2b_first");
    check("b2b_valid", rk_valid, 1);
    check("b2b_index", rk_index, 10);
    check("b2b_key",   rk_out, k2);
    drain(1'b0, -1, '0, 1'b0, '0);
    fwd_expand(got_key[10]);
    check_seq("b2b_second");
    check("b2b_second_k10", got_key[0], k2);

    for (int run = 0; run < 1000; run++) begin
      k2 = rand128();
      launch(k2);
      drain(1'b0, -1, '0, 1'b0, '0);
      fwd_expand(got_key[10]);
      check_seq("rand");
      check("rand_k10", got_key[0], k2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Sequential AES-128 inverse key-schedule generator for the decryption path. Loads the final (round-10) round key and walks the key expansion backwards, emitting round keys 10 down to 0 one per handshake on a valid/ready stream. It sits between the key register and the inverse-cipher round datapath. It reuses the same SubWord S-box substitution as forward key expansion, so no stored key table is needed.

## Interface
- NR, 10, number of rounds; only 10 (AES-128) is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load request; sampled only in IDLE.
- last_key  in  128  round-10 key; word w40 = [127:96] … w43 = [31:0].
- busy  out  1  high in RUN.
- rk_valid  out  1  round key on rk_out is valid.
- rk_ready  in  1  downstream accepts the current round key.
- rk_out  out  128  current round key, same word packing as last_key.
- rk_index  out  4  round number of rk_out, 10 down to 0.
- done  out  1  one-cycle pulse after round key 0 is accepted.

## Operation
- Reset values: busy=0, rk_valid=0, rk_out=0, rk_index=0, done=0; state=IDLE.
- States:
  - IDLE: on start=1, register last_key into the key register, set rk_index=10, go to RUN.
  - RUN: rk_valid=1. On handshake (rk_valid & rk_ready):
    - If rk_index=0: go to IDLE, pulse done, clear rk_valid.
    - Otherwise: replace the key register with the previous round key and decrement rk_index.
- Previous-round computation, from current words k0..k3 at round r (r = rk_index):
  - p3 = k3 ^ k2.
  - p2 = k2 ^ k1.
  - p1 = k1 ^ k0.
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ Rcon(r).
- RotWord(x) = {x[23:0], x[31:24]}. SubWord applies the AES forward S-box to each byte.
- Rcon(r) = {rc, 24'h0}, with rc for r=1..10 = 01,02,04,08,10,20,40,80,1b,36. Rcon is a constant lookup on rk_index; it is not an iterated inverse xtime.
- No backpressure loss: while rk_valid=1 and rk_ready=0, rk_out and rk_index are held stable.
- start in RUN is ignored; a new load needs a return to IDLE.
- last_key is sampled only in the start cycle; later changes have no effect.
- Reset mid-operation: immediately returns all outputs to reset values. No done pulse is generated.

## Timing
- start in cycle N (IDLE): busy=1, rk_valid=1, rk_index=10 and rk_out=last_key from cycle N+1.
- Each handshake in cycle M presents the next key in cycle M+1. With rk_ready held at 1, the eleven keys occupy eleven consecutive cycles, N+1..N+11.
- Final handshake (index 0) in cycle M: done=1 and busy=0 in cycle M+1, for one cycle only.
- A start in that same cycle M+1 is accepted, because the block is already in IDLE.
- The combinational path is one SubWord plus XORs, from the key register back to itself. No output depends combinationally on rk_ready, except through the registered state update.

## Structure
- Shared package aes_pkg holds:
  - state enum {IDLE, RUN};
  - the round-key width constant (128);
  - the RCON byte table indexed by round 1..10.
- One sub-module: aes_subword32, a 32-bit SubWord built from four instances of the existing byte S-box S_Sbox. It is also usable by the forward key expansion.
- Top level contains the FSM, key register, rk_index counter, and inverse-step XOR network.

## Test plan
- FIPS-197 vector: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1.
  - Required: index 10 rk_out = last_key.
  - Required: index 9 = ac7766f319fadc2128d12941575c006e.
  - Required: index 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: done pulses exactly one cycle after the index-0 beat.
- Backpressure: rk_ready toggles 1,0,0,1,… for the whole run.
  - Required: rk_out and rk_index are stable in every stalled cycle.
  - Required: the sequence is identical to the first scenario.
  - Required: total length 11 beats.
- start=1 pulsed again at index 6 with a different last_key.
  - Required: ignored; the sequence completes with the original keys.
- rst_n asserted low at index 4.
  - Required: all outputs 0 asynchronously; no done pulse.
  - Required: after release, a fresh start reproduces the full 10→0 sequence.
- Back-to-back: start asserted in the cycle done=1.
  - Required: accepted; next cycle shows index 10 with the new last_key.
- Random keys, 1000 runs.
  - Required: rk_index=0 key run through a forward-expansion reference model reproduces every emitted round key.
